// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a FIFO one word at a time and sends each word as a
// UART frame (start bit, data LSB first, stop bit(s)) on a single line.
// Bit timing is a fixed clocks-per-bit divider in the system clock domain.
module fifo_uart_tx #(
    parameter int width        = 4,
    parameter int clks_per_bit = 4,
    parameter int stop_bits    = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic             empty,
    input  logic [width-1:0] fifo_data,
    output logic             pop,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int BAUD_W = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    localparam int BIT_W  = (width > 1) ? $clog2(width + 1) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(clks_per_bit - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(width - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(stop_bits - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              r_state;
    logic [BAUD_W-1:0]   r_baud;
    logic [BIT_W-1:0]    r_bit;
    logic [width-1:0]    r_shift;
    logic                r_tx;
    logic                r_pop;
    logic                r_busy;
    logic                r_done;

    state_t              w_state;
    logic [BAUD_W-1:0]   w_baud;
    logic [BIT_W-1:0]    w_bit;
    logic [width-1:0]    w_shift;
    logic                w_tx;
    logic                w_pop;
    logic                w_busy;
    logic                w_done;
    logic                w_baud_end;

    // Next-state and next-output logic; every output is computed one cycle
    // ahead so that the registered outputs line up with the state they describe.
    always_comb begin
        w_state    = r_state;
        w_baud     = r_baud;
        w_bit      = r_bit;
        w_shift    = r_shift;
        w_tx       = r_tx;
        w_pop      = 1'b0;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_baud_end = (r_baud == BAUD_LAST);

        case (r_state)
            S_IDLE: begin
                w_tx   = 1'b1;
                w_busy = 1'b0;
                w_baud = '0;
                w_bit  = '0;
                // The head word is latched here, so later FIFO activity
                // cannot disturb the frame in flight.
                if (enable && !empty) begin
                    w_shift = fifo_data;
                    w_pop   = 1'b1;
                    w_tx    = 1'b0;
                    w_busy  = 1'b1;
                    w_state = S_START;
                end
            end

            S_START: begin
                if (w_baud_end) begin
                    w_baud  = '0;
                    w_tx    = r_shift[0];
                    w_state = S_DATA;
                end else begin
                    w_baud = r_baud + 1'b1;
                end
            end

            S_DATA: begin
                if (w_baud_end) begin
                    w_baud = '0;
                    if (r_bit == BIT_LAST) begin
                        // Bit counter is reused to count stop bits.
                        w_bit   = '0;
                        w_tx    = 1'b1;
                        w_state = S_STOP;
                    end else begin
                        w_bit   = r_bit + 1'b1;
                        w_shift = r_shift >> 1;
                        w_tx    = w_shift[0];
                    end
                end else begin
                    w_baud = r_baud + 1'b1;
                end
            end

            S_STOP: begin
                if (w_baud_end) begin
                    w_baud = '0;
                    if (r_bit == STOP_LAST) begin
                        w_bit   = '0;
                        w_tx    = 1'b1;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        w_state = S_IDLE;
                    end else begin
                        w_bit = r_bit + 1'b1;
                    end
                end else begin
                    w_baud = r_baud + 1'b1;
                end
            end

            default: begin
                w_tx    = 1'b1;
                w_busy  = 1'b0;
                w_baud  = '0;
                w_bit   = '0;
                w_state = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any frame in progress at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_pop   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_baud  <= w_baud;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_tx    <= w_tx;
            r_pop   <= w_pop;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    assign pop        = r_pop;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural FIFOs feed two instances (4 clocks/bit
// with 1 stop bit, and 1 clock/bit with 2 stop bits); a receiver model
// decodes frames and checks them against a queue of expected words.
module tb_fifo_uart_tx;

    localparam int W    = 4;
    localparam int CPB  = 4;
    localparam int SB   = 1;
    localparam int FLEN = (1 + W + SB) * CPB;

    logic         clk = 1'b0;
    logic         rstn;
    logic         en_a, empty_a, pop_a, tx_a, busy_a, done_a;
    logic [W-1:0] data_a;
    logic         en_b, empty_b, pop_b, tx_b, busy_b, done_b;
    logic [W-1:0] data_b;

    logic [W-1:0] fq_a[$];
    logic [W-1:0] fq_b[$];
    logic [W-1:0] exp_a[$];
    logic         exp_txb[$];
    int           start_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rx_idx = -1;
    int slot;
    logic [W-1:0] rx_data;
    int pop_cnt_a = 0, done_cnt_a = 0, pop_cnt_b = 0, done_cnt_b = 0;
    logic b_run = 1'b0;
    logic e_b;
    logic [W-1:0] e_word;

    fifo_uart_tx #(.width(W), .clks_per_bit(CPB), .stop_bits(SB)) u_dut_a (
        .clk(clk), .rstn(rstn), .enable(en_a), .empty(empty_a),
        .fifo_data(data_a), .pop(pop_a), .tx(tx_a), .busy(busy_a),
        .frame_done(done_a)
    );

    fifo_uart_tx #(.width(W), .clks_per_bit(1), .stop_bits(2)) u_dut_b (
        .clk(clk), .rstn(rstn), .enable(en_b), .empty(empty_b),
        .fifo_data(data_b), .pop(pop_b), .tx(tx_b), .busy(busy_b),
        .frame_done(done_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_a(input logic [W-1:0] w);
        fq_a.push_back(w);
        exp_a.push_back(w);
        empty_a = 1'b0;
        data_a  = fq_a[0];
    endtask

    task automatic push_b(input logic [W-1:0] w);
        fq_b.push_back(w);
        empty_b = 1'b0;
        data_b  = fq_b[0];
    endtask

    task automatic wait_start_a(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_a == 1'b0) break;
        end
        if (i == budget) chk("start_timeout", 0, 1);
    endtask

    task automatic wait_done_a(input int n, input int budget);
        int target;
        int i;
        target = done_cnt_a + n;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt_a >= target) break;
        end
        if (i == budget) chk("done_timeout", done_cnt_a, target);
    endtask

    // Behavioural FIFOs: the head leaves when the DUT's pop pulse is seen.
    always @(negedge clk) begin
        if (pop_a && fq_a.size() > 0) void'(fq_a.pop_front());
        empty_a = (fq_a.size() == 0);
        data_a  = (fq_a.size() > 0) ? fq_a[0] : '0;
        if (pop_b && fq_b.size() > 0) void'(fq_b.pop_front());
        empty_b = (fq_b.size() == 0);
        data_b  = (fq_b.size() > 0) ? fq_b[0] : '0;
    end

    // Receiver model and scoreboard for instance A.
    always @(negedge clk) begin
        cyc++;
        if (!rstn) begin
            rx_idx = -1;
            chk("rst_tx", tx_a, 1);
            chk("rst_pop", pop_a, 0);
            chk("rst_busy", busy_a, 0);
            chk("rst_done", done_a, 0);
        end else begin
            if (pop_a) pop_cnt_a++;
            if (done_a) done_cnt_a++;
            if (rx_idx < 0 && tx_a == 1'b0) begin
                rx_idx = 0;
                start_q.push_back(cyc);
            end
            if (rx_idx < 0) begin
                chk("idle_busy", busy_a, 0);
                chk("idle_pop", pop_a, 0);
                chk("idle_done", done_a, 0);
            end else if (rx_idx < FLEN) begin
                slot = rx_idx / CPB;
                chk("frame_busy", busy_a, 1);
                chk("frame_pop", pop_a, (rx_idx == 0) ? 1 : 0);
                chk("frame_done_early", done_a, 0);
                if (slot == 0) chk("start_bit", tx_a, 0);
                else if (slot <= W) begin
                    if (rx_idx % CPB == CPB / 2) rx_data[slot-1] = tx_a;
                end else chk("stop_bit", tx_a, 1);
                rx_idx++;
            end else begin
                chk("end_done", done_a, 1);
                chk("end_busy", busy_a, 0);
                chk("end_tx", tx_a, 1);
                if (exp_a.size() == 0) chk("sb_unexpected", int'(rx_data), -1);
                else begin
                    e_word = exp_a.pop_front();
                    chk("sb_data", int'(rx_data), int'(e_word));
                end
                rx_idx = -1;
            end
        end
    end

    // Line checker for instance B against a hand-written bit sequence.
    always @(negedge clk) begin
        if (rstn) begin
            if (pop_b) pop_cnt_b++;
            if (done_b) done_cnt_b++;
            if (exp_txb.size() > 0 && (b_run || tx_b == 1'b0)) begin
                b_run = 1'b1;
                e_b = exp_txb.pop_front();
                chk("b_tx_seq", tx_b, e_b);
                if (exp_txb.size() == 0) b_run = 1'b0;
            end
        end
    end

    initial begin
        int p0, d0, s0, ones;
        logic seq6 [15];
        rstn = 1'b0; en_a = 1'b0; en_b = 1'b0;
        empty_a = 1'b1; data_a = '0; empty_b = 1'b1; data_b = '0;
        run(3);
        rstn = 1'b1;

        // Test 1: reset while idle, outputs hold with empty FIFO afterwards
        run(5);
        #2 rstn = 1'b0;
        #1;
        chk("t1_tx", tx_a, 1); chk("t1_pop", pop_a, 0);
        chk("t1_busy", busy_a, 0); chk("t1_done", done_a, 0);
        run(2);
        rstn = 1'b1;
        en_a = 1'b1;
        run(6);
        chk("t1_hold_tx", tx_a, 1); chk("t1_hold_busy", busy_a, 0);
        chk("t1_no_start", start_q.size(), 0);

        // Test 2: single word 0xA
        p0 = pop_cnt_a; d0 = done_cnt_a;
        push_a(4'hA);
        wait_done_a(1, 60);
        run(3);
        chk("t2_pops", pop_cnt_a - p0, 1);
        chk("t2_dones", done_cnt_a - d0, 1);

        // Test 3: four words back-to-back
        en_a = 1'b0;
        run(2);
        p0 = pop_cnt_a; s0 = start_q.size();
        for (int k = 0; k < 4; k++) push_a(W'(k));
        en_a = 1'b1;
        wait_done_a(4, 200);
        run(3);
        chk("t3_pops", pop_cnt_a - p0, 4);
        chk("t3_fifo_empty", empty_a, 1);
        chk("t3_starts", start_q.size() - s0, 4);
        if (start_q.size() - s0 == 4)
            for (int k = 1; k < 4; k++)
                chk("t3_period", start_q[s0+k] - start_q[s0+k-1], FLEN + 1);

        // Test 4: enable low holds words; drop enable mid-frame
        en_a = 1'b0;
        p0 = pop_cnt_a; d0 = done_cnt_a; s0 = start_q.size();
        push_a(4'hC); push_a(4'h3);
        ones = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (tx_a) ones++;
        end
        chk("t4_tx_idle", ones, 50);
        chk("t4_no_pop", pop_cnt_a - p0, 0);
        en_a = 1'b1;
        wait_start_a(10);
        run(13);
        en_a = 1'b0;
        wait_done_a(1, 60);
        run(40);
        chk("t4_pops", pop_cnt_a - p0, 1);
        chk("t4_dones", done_cnt_a - d0, 1);
        chk("t4_left", fq_a.size(), 1);
        en_a = 1'b1;
        wait_done_a(1, 60);
        en_a = 1'b0;
        run(2);

        // Test 5: reset during data bit 1 of 0x5, then next word goes out
        push_a(4'h5); push_a(4'h9);
        d0 = done_cnt_a;
        en_a = 1'b1;
        wait_start_a(10);
        run(9);
        chk("t5_pre_tx", tx_a, 0);
        #2 rstn = 1'b0;
        #1;
        chk("t5_rst_tx", tx_a, 1); chk("t5_rst_busy", busy_a, 0);
        e_word = exp_a.pop_front();
        run(2);
        chk("t5_no_done", done_cnt_a - d0, 0);
        rstn = 1'b1;
        wait_done_a(1, 60);
        en_a = 1'b0;
        run(3);
        chk("t5_dones", done_cnt_a - d0, 1);

        // Test 6: 1 clock/bit, 2 stop bits, 0xF then 0x0
        seq6 = '{0,1,1,1,1,1,1, 1, 0,0,0,0,0,1,1};
        for (int k = 0; k < 15; k++) exp_txb.push_back(seq6[k]);
        push_b(4'hF); push_b(4'h0);
        en_b = 1'b1;
        for (int k = 0; k < 40 && exp_txb.size() > 0; k++) @(negedge clk);
        chk("t6_seq_left", exp_txb.size(), 0);
        en_b = 1'b0;
        run(3);
        chk("t6_pops", pop_cnt_b, 2);
        chk("t6_dones", done_cnt_b, 2);

        chk("sb_drained", exp_a.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream consumer of the FIFO: whenever the FIFO is non-empty and the block is enabled, it pops one word and transmits it on a single serial line as a UART-style frame.
- Frame format: start bit, then data bits LSB first, then stop bit(s).
- Bit timing comes from a fixed clocks-per-bit divider in the system clock domain.
- It is the drain side of the FIFO's push/pop pair; its pop and the FIFO's empty and data outputs connect directly.

Parameters:
- width, 4, data word width; must match the FIFO's width; legal range >= 1
- clks_per_bit, 4, clock cycles per serial bit; legal range >= 1
- stop_bits, 1, number of stop bits; legal values 1 or 2

Ports:
- clk  input  1  system clock, rising edge
- rstn  input  1  reset; asynchronous, active-low
- enable  input  1  permits starting a new frame
- empty  input  1  from FIFO: high when the FIFO holds no word
- fifo_data  input  width  from FIFO out: head word, valid whenever empty is low
- pop  output  1  to FIFO: one-cycle pulse; the FIFO removes its head word at the rising edge that ends the pulse
- tx  output  1  serial line; idle high
- busy  output  1  high while a frame is in progress (state != IDLE)
- frame_done  output  1  one-cycle pulse when a frame completes

Behaviour:
- All outputs are registered.
- Reset (rstn=0, asynchronous):
  - state=IDLE, tx=1, pop=0, busy=0, frame_done=0.
  - Shift register and counters are cleared.
  - Takes effect immediately, including mid-frame; tx returns high at once.
  - A word already popped is discarded; there is no replay.
- States: IDLE -> START -> DATA -> STOP -> IDLE.
- Per-bit timing: a baud counter (width clog2(clks_per_bit), minimum 1 bit) counts 0..clks_per_bit-1. Each state/bit lasts exactly clks_per_bit cycles.
- IDLE:
  - tx=1, busy=0.
  - At an edge where enable=1 and empty=0: capture fifo_data into the shift register, set pop<=1, tx<=0, busy<=1, state<=START.
- pop timing: pop is high for exactly the first START cycle and low otherwise. Exactly one pop per frame. No pop when empty=1 or enable=0.
- START: tx=0 for clks_per_bit cycles, then enter DATA.
- DATA:
  - tx = shift register bit 0.
  - After each clks_per_bit period, shift right and increment the bit counter (width clog2(width+1)).
  - After width bits, enter STOP.
- STOP: tx=1 for stop_bits*clks_per_bit cycles.
- Frame end: at the edge ending STOP, state<=IDLE, busy<=0, frame_done<=1 for one cycle.
- Frame length: (1+width+stop_bits)*clks_per_bit cycles, counted from the first tx=0 cycle through the last stop cycle.
- Back-to-back frames: IDLE lasts at least one cycle between frames (tx=1). Frame-start period is (1+width+stop_bits)*clks_per_bit + 1 cycles.
- enable deasserted mid-frame: the current frame completes normally; no further pop until enable=1.
- empty or fifo_data changing mid-frame: no effect (the data was latched at start).
- clks_per_bit=1: every bit lasts one cycle; the same rules apply.

Test Plan:
1. Reset with width=4, clks_per_bit=4, stop_bits=1: assert rstn=0 mid-simulation -> tx=1, pop=0, busy=0, frame_done=0 in the same cycle; these values hold while empty=1 after release.
2. Push 4'hA, enable=1 -> pop high exactly 1 cycle. tx sequence, each level for 4 cycles: 0, 0, 1, 0, 1, 1. busy high for 24 cycles. frame_done pulses once. Receiver model decodes 0xA.
3. Fill the FIFO with 0,1,2,3 (until full), enable=1 -> 4 pops; frames start 25 cycles apart with exactly 1 idle tx=1 cycle between them. Decoded values are 0,1,2,3 in order. empty is high after the 4th pop.
4. FIFO holds 2 words, enable=0 -> no pop, tx=1 for 50 cycles. Raise enable, then drop it during data bit 2 of frame 1 -> frame 1 completes; only 1 pop; second word remains.
5. Reset during data bit 1 of a 0x5 frame -> tx=1 and busy=0 immediately; no frame_done. After release with enable=1, the next FIFO word is transmitted correctly.
6. clks_per_bit=1, stop_bits=2, words 0xF and 0x0 back-to-back -> frames of 7 cycles, starts 8 cycles apart; tx sequence 0,1,1,1,1,1,1, then 1 (idle cycle), then 0,0,0,0,0,1,1.
